// File: rtl/dp_ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// dp_ram_arbiter_if
// Single-beat client request bus used by each of the two arbiter clients.
//
// Signals:
//   req    client request, held until gnt is seen (or withdrawn)
//   we     op select: 1 = write, 0 = read
//   addr   target address (ADDR_W bits)
//   wdata  write data (DATA_W bits)
//   gnt    grant, combinational, one cycle per accepted op
//   rvalid registered read-data / read-error strobe
//   err    registered address-range error, one cycle after the grant
//
// Modports:
//   master  the client side (drives the request)
//   slave   the arbiter side (drives grant and response strobes)
// ---------------------------------------------------------------------------
interface dp_ram_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic              err;

    modport master (output req, we, addr, wdata, input gnt, rvalid, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, err);
endinterface

// File: rtl/dp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// dp_ram_arbiter
// Two-client arbiter in front of a DEPTH x DATA_W dual-port RAM with separate
// write and read address ports and a 1-cycle registered read.
//
// A write from one client and a read from the other are granted together,
// one on each RAM port. Two writes or two reads conflict and are resolved
// round-robin by a priority pointer that toggles only on conflict cycles.
// Addresses >= DEPTH are granted but never reach the RAM; the client gets an
// err strobe one cycle later (with rvalid and rdata = 0 for reads).
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   a, b         client buses (dp_ram_arbiter_if.slave)
//   rdata        shared read data, valid with a.rvalid or b.rvalid
//   ram_en       any RAM op issued this cycle
//   ram_wr_en    RAM write strobe, with ram_wr_addr / ram_wr_data
//   ram_rd_en    RAM read strobe, with ram_rd_addr
//   ram_rd_data  RAM read data, valid the cycle after ram_rd_en
//   conflict_cnt saturating same-type conflict counter (DPRA_STATS_EN only)
//   stats_clr    synchronous counter clear, wins over increment
//                (DPRA_STATS_EN only)
//
// Optional feature macro: DPRA_STATS_EN
// ---------------------------------------------------------------------------
module dp_ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    dp_ram_arbiter_if.slave     a,
    dp_ram_arbiter_if.slave     b,
    output logic [DATA_W-1:0]   rdata,
    output logic                ram_en,
    output logic                ram_wr_en,
    output logic                ram_rd_en,
    output logic [ADDR_W-1:0]   ram_wr_addr,
    output logic [ADDR_W-1:0]   ram_rd_addr,
    output logic [DATA_W-1:0]   ram_wr_data,
`ifdef DPRA_STATS_EN
    input  logic                stats_clr,
    output logic [15:0]         conflict_cnt,
`endif
    input  logic [DATA_W-1:0]   ram_rd_data
);

    typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

    ptr_e ptr_q;
    logic conflict;
    logic a_gnt, b_gnt;
    logic a_rvalid_q, b_rvalid_q, a_err_q, b_err_q;
    logic rd_hit_q;   // last cycle's read actually went to the RAM

    // One extra bit keeps the compare correct even when DEPTH == 2**ADDR_W.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < (ADDR_W+1)'(DEPTH);
    endfunction

    // Same-type requests from both clients need the pointer to break the tie.
    assign conflict = a.req & b.req & (a.we == b.we);

    // Grants are combinational and forced low while reset is asserted, so no
    // RAM strobe can escape during reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned infers a latch.
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (conflict) begin
                a_gnt = (ptr_q == PTR_A);
                b_gnt = (ptr_q == PTR_B);
            end else begin
                a_gnt = a.req;
                b_gnt = b.req;
            end
        end
    end

    // At most one granted write and one granted read per cycle, so a simple
    // priority mux per port is enough. Out-of-range ops leave the port idle.
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        if (a_gnt && a.we && in_range(a.addr)) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = a.addr;
            ram_wr_data = a.wdata;
        end else if (b_gnt && b.we && in_range(b.addr)) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = b.addr;
            ram_wr_data = b.wdata;
        end
        if (a_gnt && !a.we && in_range(a.addr)) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = a.addr;
        end else if (b_gnt && !b.we && in_range(b.addr)) begin
            ram_rd_en   = 1'b1;
            ram_rd_addr = b.addr;
        end
    end

    assign ram_en = ram_wr_en | ram_rd_en;

    // Response strobes are rebuilt every cycle from this cycle's grants, so
    // they self-clear as one-cycle pulses. Reset drops any in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= PTR_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of every other register.
            a_rvalid_q <= a_gnt & ~a.we;
            b_rvalid_q <= b_gnt & ~b.we;
            a_err_q    <= a_gnt & ~in_range(a.addr);
            b_err_q    <= b_gnt & ~in_range(b.addr);
            rd_hit_q   <= ram_rd_en;
            // The owner always wins a conflict, so ownership passes across.
            if (conflict) begin
                ptr_q <= (ptr_q == PTR_A) ? PTR_B : PTR_A;
            end
        end
    end

    assign a.gnt    = a_gnt;
    assign b.gnt    = b_gnt;
    assign a.rvalid = a_rvalid_q;
    assign b.rvalid = b_rvalid_q;
    assign a.err    = a_err_q;
    assign b.err    = b_err_q;

    // An out-of-range read must return zero, not stale RAM output.
    assign rdata = rd_hit_q ? ram_rd_data : '0;

`ifdef DPRA_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (stats_clr) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/dp_ram_arbiter.md
Name: dp_ram_arbiter

Overview:
Two-client arbiter in front of the 16x8 dual-port RAM (separate write and read address ports, 1-cycle registered read).
- Clients A and B each issue single-beat read or write requests over a req/gnt handshake.
- A write from one client and a read from the other are granted in the same cycle, using both RAM ports.
- Same-type conflicts (two writes or two reads) are resolved round-robin; read data returns with a registered valid strobe.

Parameters:
DATA_W, 8, data width of RAM and client data buses
ADDR_W, 5, client/RAM address width
DEPTH, 16, number of valid RAM locations; addresses >= DEPTH are rejected

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
a_req  input  1  client A request, held until granted
a_we  input  1  client A op: 1=write, 0=read
a_addr  input  ADDR_W  client A address
a_wdata  input  DATA_W  client A write data
a_gnt  output  1  client A grant, combinational, single-cycle per accepted op
a_rvalid  output  1  client A read data valid / error strobe, registered
a_err  output  1  client A address-range error, coincident with a_rvalid
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_err  same as client A, for client B
rdata  output  DATA_W  read data, shared, valid when a_rvalid or b_rvalid
ram_en  output  1  RAM enable, high when any RAM op issued this cycle
ram_wr_en  output  1  RAM write enable
ram_rd_en  output  1  RAM read enable
ram_wr_addr  output  ADDR_W  RAM write address
ram_rd_addr  output  ADDR_W  RAM read address
ram_wr_data  output  DATA_W  RAM write data
ram_rd_data  input  DATA_W  RAM read data, valid 1 cycle after ram_rd_en

Behaviour:
- Reset (async, rst=1): gnts 0, rvalids 0, errs 0, ram_en/wr_en/rd_en 0, priority pointer = A. Any in-flight read is dropped; no rvalid after reset release.
- Request classes per cycle:
  - Only one req → granted.
  - A write + B read, or vice versa → both granted; write on wr port, read on rd port.
  - Both write or both read → the pointer owner is granted. The pointer then moves to the other client; the loser holds req and wins next cycle.
  - The pointer changes only on a conflict cycle.
- Grant is combinational in the request cycle. Client must hold req/we/addr/wdata stable until gnt is seen. Deasserting req without gnt is legal: request withdrawn.
- Granted write, addr < DEPTH: ram_wr_en=1, ram_wr_addr/ram_wr_data from the granted client, same cycle.
- Granted read, addr < DEPTH: ram_rd_en=1, ram_rd_addr from the granted client. Next cycle: that client's rvalid=1, rdata=ram_rd_data.
- ram_en = ram_wr_en | ram_rd_en. Unused RAM address/data outputs are driven 0.
- Out-of-range (addr >= DEPTH): gnt still asserted, no RAM strobe.
  - Read: next cycle rvalid=1, err=1, rdata=0.
  - Write: next cycle err=1 with rvalid=0.
- Out-of-range requests still participate in arbitration and pointer update.
- Same-address write and read granted in the same cycle: the read returns the pre-write data. No bypass.
- Back-to-back: one op per client per cycle, full throughput. rvalid is a 1-cycle pulse per read.
- rvalid/err registers clear on any cycle without a corresponding grant.

Optional Feature:
DPRA_STATS_EN
- Defined: adds output conflict_cnt (16 bits), reset 0, incrementing on each same-type conflict cycle, saturating at 16'hFFFF. Also adds input stats_clr (1 bit), a synchronous clear with priority over increment.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then A writes 8'hA5 to addr 3; next cycle A reads addr 3 → a_gnt each cycle, one cycle after read a_rvalid=1, rdata=8'hA5, b_rvalid=0.
- A write addr 5 = 8'h11 and B read addr 5 in the same cycle (prior content 8'h00) → both gnt; b_rvalid next cycle with rdata=8'h00; later B read addr 5 → 8'h11.
- A and B both read (addr 1, addr 2) for 4 consecutive cycles with req held → grants alternate A,B,A,B starting from A after reset; rvalids alternate, each returning its own address data.
- B read addr 17 (DEPTH=16) → b_gnt=1, ram_rd_en=0, next cycle b_rvalid=1, b_err=1, rdata=0; A write addr 16 → a_err=1 next cycle, no RAM write.
- A read granted, rst pulsed before the next clock edge → a_rvalid stays 0 after reset, pointer=A, all RAM strobes 0.
- With DPRA_STATS_EN: 3 write-write conflicts → conflict_cnt=3; stats_clr together with a conflict → conflict_cnt=0.
